// File: rtl/demux_pkg.sv
// Shared constants for the 4-channel stream mux/demux family.
package demux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   localparam logic [SEL_W-1:0] CH0 = 2'd0;
   localparam logic [SEL_W-1:0] CH1 = 2'd1;
   localparam logic [SEL_W-1:0] CH2 = 2'd2;
   localparam logic [SEL_W-1:0] CH3 = 2'd3;

   // Next round-robin channel; wraps from the last channel back to CH0.
   function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] ptr);
      return ptr + SEL_W'(1);
   endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry register slice for a single demux output channel, with a
// saturating count of the words written into it.
module demux_chan_buf
   import demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_ready,
   input  logic              cnt_clr,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic              free,
   output logic [CNT_W-1:0]  cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // The slot can take a new word if it is empty or being drained this cycle.
   assign free = ~valid | rd_ready;

   // Buffer register: a write always wins over a drain, so a simultaneous
   // drain-and-refill keeps valid high and gives one word per clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (wr_en) begin
         valid <= 1'b1;
         data  <= wr_data;
      end else if (rd_ready) begin
         valid <= 1'b0;
      end
   end

   // Saturating write counter; clear takes priority over a coincident write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (wr_en && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer with fixed or round-robin routing
// and per-channel accepted-word counters.
module demux_1x4_stream
   import demux_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     mode_rr,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [DATA_W-1:0]        in_data,
   output logic [NUM_CH-1:0]        out_valid,
   input  logic [NUM_CH-1:0]        out_ready,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   input  logic                     cnt_clr,
   output logic [NUM_CH*CNT_W-1:0]  cnt,
   output logic [SEL_W-1:0]         rr_ptr
);

   logic [SEL_W-1:0]  dst;
   logic [NUM_CH-1:0] chan_free;
   logic [NUM_CH-1:0] wr_en;
   logic              in_xfer;

   // Destination is re-evaluated every cycle, so a stalled word follows a mode change.
   assign dst      = mode_rr ? rr_ptr : in_sel;
   assign in_ready = rst_n & chan_free[dst];
   assign in_xfer  = in_valid & in_ready;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
      assign wr_en[k] = in_xfer & (dst == SEL_W'(k));

      demux_chan_buf #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_buf (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[k]),
         .wr_data  (in_data),
         .rd_ready (out_ready[k]),
         .cnt_clr  (cnt_clr),
         .valid    (out_valid[k]),
         .data     (out_data[k*DATA_W +: DATA_W]),
         .free     (chan_free[k]),
         .cnt      (cnt[k*CNT_W +: CNT_W])
      );
   end

   // Round-robin pointer moves only on accepted words in round-robin mode and
   // otherwise holds, so switching modes never disturbs the rotation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (in_xfer && mode_rr) begin
         rr_ptr <= next_rr(rr_ptr);
      end
   end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Scoreboard bench for demux_1x4_stream: directed words with hand-picked
// destination channels, checked by an independent output monitor.
module tb_demux_1x4_stream;
   import demux_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mode_rr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_sel = 2'd0;
   logic [7:0]  in_data = 8'd0;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready = 4'b1111;
   logic [31:0] out_data;
   logic        cnt_clr = 1'b0;
   logic [31:0] cnt;
   logic [1:0]  rr_ptr;

   int testsRun  = 0;
   int failCount = 0;

   logic [7:0] expQ [4][$];

   demux_1x4_stream #(.DATA_W(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_rr   (mode_rr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .cnt       (cnt),
      .rr_ptr    (rr_ptr)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its required value.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Present one word and wait (bounded) until it is accepted; the expected
   // channel is supplied by the caller and queued for the monitor.
   task automatic applyStimulus(input logic [7:0] data, input logic [1:0] sel,
                                input logic [1:0] expCh, output int waits);
      in_valid = 1'b1;
      in_data  = data;
      in_sel   = sel;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         testsRun++;
         failCount++;
         $display("[TB] FAIL accept_timeout: in_ready %b, expected 1", in_ready);
      end else begin
         expQ[expCh].push_back(data);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every output handshake pops and compares the oldest expected word.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
               if (expQ[k].size() == 0) begin
                  testsRun++;
                  failCount++;
                  $display("[TB] FAIL unexpected_word ch%0d: got %h, expected none", k, out_data[k*8 +: 8]);
               end else begin
                  checkOutput($sformatf("word_ch%0d", k), {24'd0, out_data[k*8 +: 8]}, {24'd0, expQ[k].pop_front()});
               end
            end
         end
      end
   end

   initial begin
      int w;

      // Power-on reset state
      #2;
      checkOutput("reset_out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("reset_cnt", cnt, 32'h0);
      checkOutput("reset_rr_ptr", {30'd0, rr_ptr}, 32'h0);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Fixed routing at full throughput
      applyStimulus(8'h11, CH0, CH0, w); checkOutput("stream_ready0", w, 0);
      applyStimulus(8'h22, CH1, CH1, w); checkOutput("stream_ready1", w, 0);
      applyStimulus(8'h33, CH2, CH2, w); checkOutput("stream_ready2", w, 0);
      applyStimulus(8'h44, CH3, CH3, w); checkOutput("stream_ready3", w, 0);
      repeat (2) @(negedge clk);
      checkOutput("fixed_cnt", cnt, 32'h01010101);
      checkOutput("fixed_rr_ptr", {30'd0, rr_ptr}, 32'h0);

      // Backpressure isolation: ch0 stalled and full
      @(posedge clk); #1;
      out_ready = 4'b1110;
      applyStimulus(8'h55, CH0, CH0, w);
      in_valid = 1'b1; in_data = 8'h66; in_sel = CH0;
      @(negedge clk);
      checkOutput("bp_blocked", {31'd0, in_ready}, 32'h0);
      @(negedge clk);
      checkOutput("bp_still_blocked", {31'd0, in_ready}, 32'h0);
      @(posedge clk); #1;
      applyStimulus(8'h66, CH3, CH3, w);
      checkOutput("bp_other_ch_wait", w, 0);
      @(negedge clk);
      checkOutput("bp_ch0_valid", {31'd0, out_valid[0]}, 32'h1);
      checkOutput("bp_ch0_data", {24'd0, out_data[7:0]}, 32'h55);
      @(posedge clk); #1;
      out_ready = 4'b1111;
      repeat (2) @(negedge clk);
      checkOutput("bp_cnt", cnt, 32'h02010102);

      // Same-channel drain and refill in one cycle
      @(posedge clk); #1;
      out_ready = 4'b1101;
      applyStimulus(8'h10, CH1, CH1, w);
      out_ready = 4'b1111;
      applyStimulus(8'h20, CH1, CH1, w);
      checkOutput("replace_wait", w, 0);
      @(negedge clk);
      checkOutput("replace_valid", {31'd0, out_valid[1]}, 32'h1);
      checkOutput("replace_data", {24'd0, out_data[15:8]}, 32'h20);
      checkOutput("replace_cnt1", {24'd0, cnt[15:8]}, 32'h3);

      // Round-robin rotation starting from channel 0
      @(posedge clk); #1;
      mode_rr = 1'b1;
      applyStimulus(8'h01, CH0, CH0, w);
      applyStimulus(8'h02, CH0, CH1, w);
      applyStimulus(8'h03, CH0, CH2, w);
      applyStimulus(8'h04, CH0, CH3, w);
      applyStimulus(8'h05, CH0, CH0, w);
      applyStimulus(8'h06, CH0, CH1, w);
      @(negedge clk);
      checkOutput("rr_ptr_after6", {30'd0, rr_ptr}, 32'h2);
      @(posedge clk); #1;
      mode_rr = 1'b0;
      @(negedge clk);
      checkOutput("rr_ptr_hold_mode", {30'd0, rr_ptr}, 32'h2);
      @(posedge clk); #1;
      applyStimulus(8'h77, CH3, CH3, w);
      repeat (2) @(negedge clk);
      checkOutput("rr_ptr_fixed_hold", {30'd0, rr_ptr}, 32'h2);
      checkOutput("rr_cnt", cnt, 32'h04020504);

      // Counter saturation and clear-wins
      @(posedge clk); #1;
      for (int i = 0; i < 260; i++) applyStimulus(8'(i), CH2, CH2, w);
      repeat (2) @(negedge clk);
      checkOutput("cnt2_saturated", {24'd0, cnt[23:16]}, 32'd255);
      @(posedge clk); #1;
      cnt_clr = 1'b1;
      applyStimulus(8'h99, CH2, CH2, w);
      cnt_clr = 1'b0;
      @(negedge clk);
      checkOutput("cnt_clear_wins", cnt, 32'h0);

      // Asynchronous reset mid-stream while ch2 holds a word
      @(posedge clk); #1;
      out_ready = 4'b1011;
      applyStimulus(8'hA5, CH2, CH2, w);
      @(negedge clk);
      checkOutput("pre_reset_ch2_valid", {31'd0, out_valid[2]}, 32'h1);
      #2;
      rst_n = 1'b0;
      expQ[2].delete();
      #1;
      checkOutput("async_out_valid", {28'd0, out_valid}, 32'h0);
      checkOutput("async_cnt", cnt, 32'h0);
      checkOutput("async_rr_ptr", {30'd0, rr_ptr}, 32'h0);
      checkOutput("async_in_ready", {31'd0, in_ready}, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      out_ready = 4'b1111;
      rst_n = 1'b1;
      @(posedge clk); #1;
      applyStimulus(8'h5A, CH1, CH1, w);
      @(negedge clk);
      checkOutput("post_reset_valid", {28'd0, out_valid}, 32'h2);
      checkOutput("post_reset_data", {24'd0, out_data[15:8]}, 32'h5A);

      // Everything queued must have been seen
      repeat (4) @(negedge clk);
      checkOutput("queues_drained", expQ[0].size() + expQ[1].size() + expQ[2].size() + expQ[3].size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Registered 1-to-4 demultiplexer. It is the distribution-side counterpart of the team's 4:1 gate-level mux.
- Accepts a word on one valid/ready input stream and routes it to one of four output channels.
- Each output channel has a one-entry register buffer and its own valid/ready handshake.
- Routing is either fixed (driven by the in_sel select input) or round-robin.
- Per-channel accepted-word counters are exported for debug and status.

Parameters:
- DATA_W, 8, width of a data word.
- CNT_W, 8, width of each per-channel saturating word counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- mode_rr  input  1  0 = route by in_sel; 1 = round-robin, in_sel ignored.
- in_valid  input  1  input word present.
- in_ready  output  1  demux can accept the input word this cycle.
- in_sel  input  2  destination channel (fixed mode only).
- in_data  input  DATA_W  input word.
- out_valid  output  4  bit k = channel k buffer holds a word.
- out_ready  input  4  bit k = channel k consumer accepts this cycle.
- out_data  output  4*DATA_W  channel k word on bits [k*DATA_W +: DATA_W].
- cnt_clr  input  1  synchronous clear of all counters.
- cnt  output  4*CNT_W  channel k accepted-word count on bits [k*CNT_W +: CNT_W].
- rr_ptr  output  2  current round-robin destination.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - out_valid = 0, out_data = 0, cnt = 0, rr_ptr = 0.
  - Buffered words are discarded.
  - in_ready is low while rst_n is low.
- Destination: dst = mode_rr ? rr_ptr : in_sel.
- in_ready = rst_n & (~out_valid[dst] | out_ready[dst]). This is combinational; there is no path from in_valid to in_ready.
- Input transfer: in_valid & in_ready on a rising edge.
  - On a transfer: out_data[dst] <= in_data and out_valid[dst] <= 1.
  - The word is visible at the output one cycle after acceptance (latency 1).
- Output transfer on channel k: out_valid[k] & out_ready[k].
  - If there is no simultaneous input transfer to k, out_valid[k] <= 0. out_data[k] holds its last value.
- Output transfer and input transfer to the same channel in the same cycle:
  - out_valid[k] stays 1 and out_data[k] takes the new word.
  - This gives full throughput of one word per clock per channel.
- Independence: a stalled channel blocks only inputs destined to it. Other channels continue to drain.
- Sender rule: while in_valid & ~in_ready, the sender holds in_data and in_sel stable. The block does not check this.
- Round-robin:
  - rr_ptr advances by 1 on each input transfer when mode_rr = 1, wrapping 3 -> 0.
  - rr_ptr is not advanced when mode_rr = 0.
- Mode change:
  - mode_rr is sampled every cycle and rr_ptr holds its value across mode changes.
  - A word already in a buffer is unaffected.
  - A stalled input whose dst changes because mode_rr changed is re-evaluated against the new dst.
- Counters:
  - cnt[k] increments on each input transfer to k and saturates at 2^CNT_W - 1 (no wrap).
  - cnt_clr = 1 sets all counters to 0 on the next edge.
  - If cnt_clr and a transfer occur in the same cycle, clear wins: the count becomes 0 and that word is not counted.
- No combinational path from out_ready to out_valid or out_data.

Decomposition:
- Shared package (demux_pkg), containing:
  - NUM_CH = 4 and SEL_W = 2.
  - Channel-index helper constants CH0..CH3.
  - The same package is reused by the mux-side blocks.
- Sub-module demux_chan_buf, one-entry register slice (DATA_W and CNT_W parameters, valid/ready, saturating counter, clear), instantiated four times.
- The top level holds the dst select, the in_ready mux and rr_ptr.

Test Plan:
- Reset:
  - Stimulus: drive rst_n low mid-stream while channel 2 holds 0xA5.
  - Response: out_valid = 0000 and cnt = 0 immediately (no clock edge needed); rr_ptr = 0.
  - After release: first word with in_sel = 1 appears on channel 1 one cycle after acceptance.
- Fixed routing, full throughput:
  - Stimulus: mode_rr = 0, out_ready = 1111, send 0x11/sel0, 0x22/sel1, 0x33/sel2, 0x44/sel3 on consecutive cycles.
  - Response: each word appears on its channel one cycle later, in_ready stays 1, cnt = 1,1,1,1.
- Backpressure isolation:
  - Stimulus: out_ready[0] = 0, channel 0 full; send in_sel = 0, then in_sel = 3.
  - Response: in_ready = 0 while sel = 0. After the sender switches to sel = 3 the word is accepted on channel 3. Channel 0 still holds its word.
- Same-channel replace:
  - Stimulus: channel 1 holds 0x10, out_ready[1] = 1, input 0x20/sel1 in the same cycle.
  - Response: out_valid[1] stays 1, out_data[1] = 0x20 next cycle, cnt[1] increments.
- Round-robin:
  - Stimulus: mode_rr = 1, send 6 words 0x01..0x06 with in_sel = 0.
  - Response: the words land on channels 0,1,2,3,0,1 and rr_ptr ends at 2.
  - Then set mode_rr = 0: rr_ptr stays 2 and routing follows in_sel.
- Counter edges:
  - Stimulus: 260 transfers to channel 2 with CNT_W = 8.
  - Response: cnt[2] = 255 (saturated).
  - Then cnt_clr coincident with a transfer: cnt[2] = 0 afterwards.
